// File: rtl/cic_compensator_mc.sv
// cic_compensator_mc: time-multiplexed sparse 3-tap CIC compensator.
// y = x[n] + A*x[n-m] + x[n-2m], saturated, per-channel history.
module cic_compensator_mc #(
  parameter int InputLengthBits  = 29,
  parameter int OutputLengthBits = 36,
  parameter int FilterOrder      = 3,
  parameter int NumChannels      = 2,
  parameter int CoeffBits        = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [InputLengthBits-1:0]  in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [(NumChannels > 1 ?
                 $clog2(NumChannels) : 1)-1:0] out_channel,
  input  logic signed [CoeffBits-1:0]        coeff,
  input  logic                               coeff_load,
  output logic                               overflow
);

  localparam int IW    = InputLengthBits;
  localparam int OW    = OutputLengthBits;
  localparam int CW    = CoeffBits;
  localparam int M     = FilterOrder;
  localparam int Depth = 2 * M;
  localparam int ChW   = NumChannels > 1 ?
                         $clog2(NumChannels) : 1;
  localparam int Slots = 2 ** ChW;
  localparam int FW    = IW + CW + 2;
  localparam int SW    = (FW > OW ? FW : OW) + 1;

  localparam int ADefInt =
    (M == 1) ? -18 :
    (M <= 3) ? -10 :
    (M <= 5) ? -6  : -4;

  localparam logic signed [CW-1:0] ADef = CW'(ADefInt);

  localparam logic signed [SW-1:0] MaxV =
    {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] MinV =
    {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  if (FilterOrder < 1 || FilterOrder > 7) begin : g_bad_m
    $error("FilterOrder must be within 1..7");
  end

  if (NumChannels < 1 || NumChannels > 8) begin : g_bad_n
    $error("NumChannels must be within 1..8");
  end

  logic signed [IW-1:0] dl [Slots][Depth];
  logic        [ChW-1:0] ch;
  logic signed [CW-1:0]  a;

  logic signed [IW-1:0] tap_m;
  logic signed [IW-1:0] tap_2m;
  logic signed [FW-1:0] prod;
  logic signed [FW-1:0] sum;
  logic signed [SW-1:0] sum_x;
  logic                 sat_hi;
  logic                 sat_lo;
  logic signed [OW-1:0] y;
  logic                 accept;
  logic                 ch_last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_last  = (ch == ChW'(NumChannels - 1));

  assign tap_m  = dl[ch][M-1];
  assign tap_2m = dl[ch][Depth-1];

  assign prod  = FW'(a) * FW'(tap_m);
  assign sum   = FW'(in) + prod + FW'(tap_2m);
  assign sum_x = SW'(sum);

  // clamp the full-precision sum into the output range
  always_comb begin
    sat_hi = sum_x > MaxV;
    sat_lo = sum_x < MinV;
    y      = OW'(sum_x);
    if (sat_hi) begin
      y = OW'(MaxV);
    end else if (sat_lo) begin
      y = OW'(MinV);
    end
  end

  // coefficient register; an accept this cycle still sees the old A
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= ADef;
    end else if (coeff_load) begin
      a <= coeff;
    end
  end

  // per-channel history, shifted only for the accepted channel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < Slots; c++) begin
        for (int i = 0; i < Depth; i++) begin
          dl[c][i] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = Depth - 1; i > 0; i--) begin
        dl[ch][i] <= dl[ch][i-1];
      end
      dl[ch][0] <= in;
    end
  end

  // round-robin input channel counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (accept) begin
      ch <= ch_last ? '0 : ch + 1'b1;
    end
  end

  // single output register with valid/ready hold and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      overflow    <= 1'b0;
    end else if (accept) begin
      out         <= y;
      out_valid   <= 1'b1;
      out_channel <= ch;
      if (sat_hi || sat_lo) begin
        overflow <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
